// File: rtl/div_repsub.sv
// Unsigned repeated-subtraction divider with an operand/result handshake.
// Datapath registers and the control FSM share one module but are kept in separate blocks.
module div_repsub #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         input_available,
    input  logic [W-1:0] operands_bits_A,
    input  logic [W-1:0] operands_bits_B,
    output logic         operands_rdy,
    output logic [W-1:0] result_bits_quotient,
    output logic [W-1:0] result_bits_remainder,
    output logic         result_div_by_zero,
    output logic         result_rdy,
    input  logic         result_taken
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]   r_state;
    logic [1:0]   w_state_next;
    logic [W-1:0] r_rem;
    logic [W-1:0] r_div;
    logic [W-1:0] r_quo;
    logic         r_dbz;

    logic         w_accept;
    logic         w_zero_div;
    logic         w_ge;
    logic         w_sub;
    logic [W-1:0] w_diff;

    assign w_zero_div = (operands_bits_B == '0);
    assign w_ge       = (r_rem >= r_div);
    assign w_diff     = r_rem - r_div;

    // Control: next state and datapath strobes.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_sub        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (input_available) begin
                    w_accept     = 1'b1;
                    w_state_next = w_zero_div ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (w_ge) begin
                    w_sub = 1'b1;
                end else begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (result_taken) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath: results hold in IDLE and DONE until the next accept.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rem <= '0;
            r_div <= '0;
            r_quo <= '0;
            r_dbz <= 1'b0;
        end else if (w_accept) begin
            r_rem <= operands_bits_A;
            r_div <= operands_bits_B;
            r_quo <= w_zero_div ? '1 : '0;
            r_dbz <= w_zero_div;
        end else if (w_sub) begin
            r_rem <= w_diff;
            r_quo <= r_quo + 1'b1;
        end
    end

    assign operands_rdy          = (r_state == S_IDLE);
    assign result_rdy            = (r_state == S_DONE);
    assign result_bits_quotient  = r_quo;
    assign result_bits_remainder = r_rem;
    assign result_div_by_zero    = r_dbz;

endmodule
